// File: rtl/plat_scroll_sched.sv
// Platform table owner: initial layout load and per-request scroll with LFSR respawn.
// Optional macro PLAT_SCORE_EN adds the accumulated scroll-distance score register.
module plat_scroll_sched #(
    parameter int          NUM_PLAT  = 16,
    parameter int          Y_MAX     = 479,
    parameter int          X_MIN     = 64,
    parameter int          SPACING   = 30,
    parameter int          MAX_SHIFT = 63,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   loadplat,
    input  logic                   refresh_en,
    input  logic [9:0]             plat_temp_Y,
    output logic [NUM_PLAT*10-1:0] platX_flat,
    output logic [NUM_PLAT*10-1:0] platY_flat,
    output logic                   trigger,
    output logic                   busy,
    output logic [15:0]            score
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LATCH,
        ST_SHIFT,
        ST_DONE,
        ST_WAIT_LOW
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_PLAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [9:0]  mag_q, mag_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [9:0]  x_q [NUM_PLAT];
    logic [9:0]  y_q [NUM_PLAT];

    logic        wr_en;
    logic [9:0]  wr_x, wr_y;
    logic [9:0]  respawn_x, init_y, shift_sum, neg_y, mag_raw, mag_clamped;

    // Galois form for x^16+x^14+x^13+x^11; free-running in every state.
    assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign respawn_x = 10'(X_MIN) + {1'b0, lfsr_q[8:0]};
    assign init_y    = 10'(Y_MAX - 14) - 10'(SPACING * int'(idx_q));
    assign shift_sum = y_q[idx_q] + mag_q;

    // Only upward doodle motion (negative Y) scrolls the world.
    assign neg_y       = 10'd0 - plat_temp_Y;
    assign mag_raw     = plat_temp_Y[9] ? neg_y : 10'd0;
    assign mag_clamped = (mag_raw > 10'(MAX_SHIFT)) ? 10'(MAX_SHIFT) : mag_raw;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            mag_q   <= 10'd0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mag_q   <= mag_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mag_d   = mag_q;
        wr_en   = 1'b0;
        wr_x    = respawn_x;
        wr_y    = 10'd0;
        case (state_q)
            ST_IDLE: begin
                if (loadplat) begin
                    state_d = ST_INIT;
                    idx_d   = 4'd0;
                end else if (refresh_en) begin
                    state_d = ST_LATCH;
                end
            end
            ST_INIT: begin
                wr_en = 1'b1;
                wr_y  = init_y;
                idx_d = idx_q + 4'd1;
                if (idx_q == LAST_IDX) state_d = ST_WAIT_LOW;
            end
            ST_LATCH: begin
                mag_d   = mag_clamped;
                idx_d   = 4'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                wr_en = 1'b1;
                if (shift_sum > 10'(Y_MAX)) begin
                    wr_y = shift_sum - 10'(Y_MAX + 1);
                end else begin
                    wr_y = shift_sum;
                    wr_x = x_q[idx_q];
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == LAST_IDX) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_WAIT_LOW;
            ST_WAIT_LOW: begin
                // Hold here until both request levels drop so a held level cannot re-fire.
                if (!refresh_en && !loadplat) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                x_q[i] <= 10'd0;
                y_q[i] <= 10'd0;
            end
        end else if (wr_en) begin
            x_q[idx_q] <= wr_x;
            y_q[idx_q] <= wr_y;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PLAT; gi++) begin : g_flat
            assign platX_flat[10*gi +: 10] = x_q[gi];
            assign platY_flat[10*gi +: 10] = y_q[gi];
        end
    endgenerate

    assign trigger = (state_q == ST_DONE);
    assign busy    = (state_q == ST_INIT) || (state_q == ST_LATCH) ||
                     (state_q == ST_SHIFT) || (state_q == ST_DONE);

`ifdef PLAT_SCORE_EN
    logic [15:0] score_q;
    logic [16:0] score_sum;

    assign score_sum = {1'b0, score_q} + {7'd0, mag_q};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_q <= 16'h0000;
        end else if (state_q == ST_IDLE && loadplat) begin
            score_q <= 16'h0000;
        end else if (state_q == ST_DONE) begin
            score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    assign score = score_q;
`else
    assign score = 16'h0000;
`endif

endmodule

// File: tb/tb_plat_scroll_sched.sv
// Self-checking bench for plat_scroll_sched: cycle-by-cycle model comparison plus directed literal checks.
module tb_plat_scroll_sched;

    logic         Clk        = 1'b0;
    logic         Reset_n    = 1'b1;
    logic         loadplat   = 1'b0;
    logic         refresh_en = 1'b0;
    logic [9:0]   plat_temp_Y = 10'd0;
    logic [159:0] platX_flat, platY_flat;
    logic         trigger, busy;
    logic [15:0]  score;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    plat_scroll_sched dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .loadplat   (loadplat),
        .refresh_en (refresh_en),
        .plat_temp_Y(plat_temp_Y),
        .platX_flat (platX_flat),
        .platY_flat (platY_flat),
        .trigger    (trigger),
        .busy       (busy),
        .score      (score)
    );

    task automatic chk(input string name, input int idx, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0d expected=%0d at t=%0t", name, idx, act, exp, $time);
        end
    endtask

    function automatic int get_y(input int i);
        return int'(platY_flat[10*i +: 10]);
    endfunction

    function automatic int get_x(input int i);
        return int'(platX_flat[10*i +: 10]);
    endfunction

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 loading, 2 scrolling, 3 waiting for inputs low.
    // step k: load writes entry k; scroll step 0 latches, 1..16 move entry k-1, 17 completes.
    int          m_phase = 0;
    int          m_k     = 0;
    int          m_mag   = 0;
    int          m_score = 0;
    int          mX [16] = '{default: 0};
    int          mY [16] = '{default: 0};
    logic [15:0] m_lfsr  = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int mag_of(input logic [9:0] p);
        int v;
        v = int'($signed(p));
        if (v >= 0) return 0;
        if (-v > 63) return 63;
        return -v;
    endfunction

    function automatic int moved_y(input int y, input int mag);
        return (y + mag > 479) ? (y + mag - 480) : (y + mag);
    endfunction

    function automatic int moved_x(input int x, input int y, input int mag, input logic [15:0] l);
        return (y + mag > 479) ? (64 + int'(l[8:0])) : x;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_phase <= 0;
            m_k     <= 0;
            m_mag   <= 0;
            m_score <= 0;
            m_lfsr  <= 16'hACE1;
            for (int i = 0; i < 16; i++) begin
                mX[i] <= 0;
                mY[i] <= 0;
            end
        end else begin
            m_lfsr <= lfsr_next(m_lfsr);
            case (m_phase)
                0: begin
                    if (loadplat) begin
                        m_phase <= 1;
                        m_k     <= 0;
                        m_score <= 0;
                    end else if (refresh_en) begin
                        m_phase <= 2;
                        m_k     <= 0;
                    end
                end
                1: begin
                    mX[m_k] <= 64 + int'(m_lfsr[8:0]);
                    mY[m_k] <= 465 - 30 * m_k;
                    if (m_k == 15) m_phase <= 3;
                    else m_k <= m_k + 1;
                end
                2: begin
                    if (m_k == 0) begin
                        m_mag <= mag_of(plat_temp_Y);
                        m_k   <= 1;
                    end else if (m_k <= 16) begin
                        mY[m_k-1] <= moved_y(mY[m_k-1], m_mag);
                        mX[m_k-1] <= moved_x(mX[m_k-1], mY[m_k-1], m_mag, m_lfsr);
                        m_k <= m_k + 1;
                    end else begin
                        m_score <= (m_score + m_mag > 65535) ? 65535 : m_score + m_mag;
                        m_phase <= 3;
                    end
                end
                default: begin
                    if (!refresh_en && !loadplat) m_phase <= 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge Clk) begin
        chk("busy", 0, busy, (m_phase == 1 || m_phase == 2) ? 1 : 0);
        chk("trigger", 0, trigger, (m_phase == 2 && m_k == 17) ? 1 : 0);
`ifdef PLAT_SCORE_EN
        chk("score", 0, score, m_score);
`else
        chk("score", 0, score, 0);
`endif
        for (int i = 0; i < 16; i++) begin
            chk("X", i, get_x(i), mX[i]);
            chk("Y", i, get_y(i), mY[i]);
        end
    end

    // ---------------- directed stimulus ----------------
    // Cycle 0 is the cycle in which the caller just changed inputs.
    task automatic run_window(input int n, output int first_trig, output int ntrig, output int nbusy);
        first_trig = -1;
        ntrig      = 0;
        nbusy      = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge Clk);
            if (trigger) begin
                if (ntrig == 0) first_trig = c;
                ntrig++;
            end
            if (busy) nbusy++;
            @(posedge Clk);
            #2;
        end
    endtask

    initial begin
        int ft, nt, nb, ft2, nt2, nb2, x1_saved;
        int snap [16];

        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Reset_n = 1'b1;
        @(negedge Clk);
        chk("rst_busy", 0, busy, 0);
        chk("rst_y0", 0, get_y(0), 0);
        @(posedge Clk);
        #2;

        // initial layout load
        loadplat = 1'b1;
        run_window(1, ft, nt, nb);
        loadplat = 1'b0;
        run_window(24, ft2, nt2, nb2);
        chk("load_trig_count", 0, nt + nt2, 0);
        chk("load_busy_cycles", 0, nb + nb2, 16);
        chk("load_y0", 0, get_y(0), 465);
        chk("load_y15", 0, get_y(15), 15);
        for (int i = 0; i < 16; i++)
            chk("load_x_in_range", i, (get_x(i) >= 64 && get_x(i) <= 575) ? 1 : 0, 1);

        // scroll by 5 with refresh held long past completion
        plat_temp_Y = 10'h3FB;
        refresh_en  = 1'b1;
        run_window(30, ft, nt, nb);
        chk("s5_trig_cycle", 0, ft, 18);
        chk("s5_trig_count", 0, nt, 1);
        chk("s5_busy_cycles", 0, nb, 18);
        refresh_en = 1'b0;
        run_window(2, ft2, nt2, nb2);
        chk("s5_y0", 0, get_y(0), 470);
        chk("s5_y15", 0, get_y(15), 20);
`ifdef PLAT_SCORE_EN
        chk("s5_score", 0, score, 5);
`endif

        // scroll by 15: entry 0 wraps 470 -> 5, entry 1 keeps its X
        x1_saved    = get_x(1);
        plat_temp_Y = 10'h3F1;
        refresh_en  = 1'b1;
        run_window(20, ft, nt, nb);
        chk("s15_trig_cycle", 0, ft, 18);
        refresh_en = 1'b0;
        run_window(2, ft2, nt2, nb2);
        chk("s15_y0_wrap", 0, get_y(0), 5);
        chk("s15_y1", 1, get_y(1), 455);
        chk("s15_x1_kept", 1, get_x(1), x1_saved);
        chk("s15_x0_range", 0, (get_x(0) >= 64 && get_x(0) <= 575) ? 1 : 0, 1);

        // downward motion: table unchanged, trigger still pulses
        for (int i = 0; i < 16; i++) snap[i] = get_y(i);
        plat_temp_Y = 10'h003;
        refresh_en  = 1'b1;
        run_window(20, ft, nt, nb);
        chk("pos_trig_cycle", 0, ft, 18);
        chk("pos_trig_count", 0, nt, 1);
        refresh_en = 1'b0;
        run_window(2, ft2, nt2, nb2);
        for (int i = 0; i < 16; i++) chk("pos_y_unchanged", i, get_y(i), snap[i]);

        // most negative input clamps to 63
        plat_temp_Y = 10'h200;
        refresh_en  = 1'b1;
        run_window(20, ft, nt, nb);
        refresh_en = 1'b0;
        run_window(2, ft2, nt2, nb2);
        chk("clamp_y0", 0, get_y(0), 68);
        chk("clamp_y1_wrap", 1, get_y(1), 38);
        chk("clamp_y15", 15, get_y(15), 98);

        // both requests together: load wins, no trigger
        loadplat   = 1'b1;
        refresh_en = 1'b1;
        run_window(1, ft, nt, nb);
        loadplat   = 1'b0;
        refresh_en = 1'b0;
        run_window(24, ft2, nt2, nb2);
        chk("both_trig_count", 0, nt + nt2, 0);
        chk("both_y0", 0, get_y(0), 465);

        // refresh re-raised during SHIFT is ignored
        plat_temp_Y = 10'h3FB;
        refresh_en  = 1'b1;
        run_window(1, ft, nt, nb);
        refresh_en = 1'b0;
        run_window(4, ft2, nt2, nb2);
        nt = nt + nt2;
        refresh_en = 1'b1;
        run_window(6, ft2, nt2, nb2);
        nt = nt + nt2;
        refresh_en = 1'b0;
        run_window(20, ft2, nt2, nb2);
        chk("mid_shift_trig_cycle", 0, ft2, 7);
        chk("mid_shift_trig_count", 0, nt + nt2, 1);

        // reset in the middle of SHIFT
        plat_temp_Y = 10'h3F1;
        refresh_en  = 1'b1;
        run_window(8, ft, nt, nb);
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("arst_busy", 0, busy, 0);
        chk("arst_trigger", 0, trigger, 0);
        chk("arst_xflat_zero", 0, (platX_flat == '0) ? 1 : 0, 1);
        chk("arst_yflat_zero", 0, (platY_flat == '0) ? 1 : 0, 1);
        refresh_en = 1'b0;
        @(posedge Clk);
        #2 Reset_n = 1'b1;
        run_window(3, ft, nt, nb);
        chk("arst_idle_busy", 0, nb, 0);
        chk("arst_idle_trig", 0, nt, 0);

        // reload after reset: X values follow the re-seeded LFSR (checked per cycle)
        loadplat = 1'b1;
        run_window(1, ft, nt, nb);
        loadplat = 1'b0;
        run_window(24, ft2, nt2, nb2);
        chk("reload_y15", 15, get_y(15), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
